exu_wb_arb: RTL



---
 rtl/exu_wb_arb_pkg.sv | 19 +
 rtl/exu_wb_arb_if.sv | 35 +++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/exu_wb_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the execution-unit writeback arbiter: the buffered request
// record and the requester index map.
package exu_wb_arb_pkg;

    localparam int XLEN = 32;

    localparam int WB_ALU = 0;
    localparam int WB_MUL = 1;
    localparam int WB_DIV = 2;
    localparam int WB_LSU = 3;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] instr_tag;
        logic [31:0]     instr;
    } wb_req_t;

endpackage

// File: rtl/exu_wb_arb_if.sv
// Functional-unit writeback requests in, single register-file write port and
// issue back-pressure out.
interface exu_wb_arb_if #(
    parameter int NREQ = 4
);
    import exu_wb_arb_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][4:0]       req_rd_addr;
    logic [NREQ-1:0][XLEN-1:0]  req_data;
    logic [NREQ-1:0][XLEN-1:0]  req_instr_tag;
    logic [NREQ-1:0][31:0]      req_instr;

    logic                       wb_rd_wr_en;
    logic [4:0]                 wb_rd_addr;
    logic [XLEN-1:0]            wb_data;
    logic [XLEN-1:0]            wb_instr_tag;
    logic [31:0]                wb_instr;
    logic [NREQ-1:0]            wb_grant;
    logic                       wb_stall;
    logic                       ovf_err;

    modport master (
        output req_valid, req_rd_addr, req_data, req_instr_tag, req_instr,
        input  wb_rd_wr_en, wb_rd_addr, wb_data, wb_instr_tag, wb_instr,
               wb_grant, wb_stall, ovf_err
    );

    modport slave (
        input  req_valid, req_rd_addr, req_data, req_instr_tag, req_instr,
        output wb_rd_wr_en, wb_rd_addr, wb_data, wb_instr_tag, wb_instr,
               wb_grant, wb_stall, ovf_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-requester synchronous FIFO of writeback records. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module wb_fifo
    import exu_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_req_t                      push_data,
    input  logic                         pop,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t         mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: buffers each functional unit's completions and grants one
// per cycle to the registered register-file write port, with anti-starvation.
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    exu_wb_arb_if.slave       bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    wb_req_t          in_req_s   [NREQ];
    wb_req_t          fifo_head_s[NREQ];
    wb_req_t          head_s     [NREQ];
    wb_req_t          sel_s;
    logic [CW-1:0]    count_s    [NREQ];
    logic [WW-1:0]    wait_r     [NREQ];
    logic [NREQ-1:0]  in_ok_s, head_valid_s, starved_s, grant_s;
    logic [NREQ-1:0]  push_s, pop_s, drop_s, full_s, empty_s, near_full_s;

    logic             wb_rd_wr_en_r;
    logic [4:0]       wb_rd_addr_r;
    logic [XLEN-1:0]  wb_data_r;
    logic [XLEN-1:0]  wb_instr_tag_r;
    logic [31:0]      wb_instr_r;
    logic [NREQ-1:0]  wb_grant_r;
    logic             ovf_r;

    // Highest-index set bit wins, matching LSU > DIV > MUL > ALU.
    function automatic logic [NREQ-1:0] pick_highest(input logic [NREQ-1:0] cand);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand[i]) begin
                onehot = NREQ'(1) << i;
            end else begin
                onehot = onehot;
            end
        end
        return onehot;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign in_req_s[g].rd_addr   = bus.req_rd_addr[g];
        assign in_req_s[g].data      = bus.req_data[g];
        assign in_req_s[g].instr_tag = bus.req_instr_tag[g];
        assign in_req_s[g].instr     = bus.req_instr[g];
        assign in_ok_s[g]     = bus.req_valid[g] && (bus.req_rd_addr[g] != 5'd0);
        assign near_full_s[g] = (count_s[g] >= CW'(DEPTH - 1));

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[g]),
            .push_data (in_req_s[g]),
            .pop       (pop_s[g]),
            .head      (fifo_head_s[g]),
            .count     (count_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g])
        );
    end

    // Effective heads (buffered entry, else bypass of the incoming request) and arbitration.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            head_valid_s[i] = !empty_s[i] || in_ok_s[i];
            head_s[i]       = empty_s[i] ? in_req_s[i] : fifo_head_s[i];
            starved_s[i]    = head_valid_s[i] && (wait_r[i] == WW'(STARVE_LIMIT));
        end
        if (|starved_s) begin
            grant_s = pick_highest(starved_s);
        end else begin
            grant_s = pick_highest(head_valid_s);
        end
    end

    // Queue bookkeeping: a granted bypass never enters the FIFO, a losing one does.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            pop_s[i]  = grant_s[i] && !empty_s[i];
            push_s[i] = in_ok_s[i] && !(grant_s[i] && empty_s[i]);
            drop_s[i] = push_s[i] && full_s[i] && !pop_s[i];
            if (grant_s[i]) begin
                sel_s = head_s[i];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Wait counters, sticky overflow and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_r[i] <= '0;
            end
            wb_rd_wr_en_r  <= 1'b0;
            wb_rd_addr_r   <= 5'd0;
            wb_data_r      <= '0;
            wb_instr_tag_r <= '0;
            wb_instr_r     <= 32'd0;
            wb_grant_r     <= '0;
            ovf_r          <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (head_valid_s[i] && !grant_s[i]) begin
                    if (wait_r[i] != WW'(STARVE_LIMIT)) begin
                        wait_r[i] <= wait_r[i] + WW'(1);
                    end
                end else begin
                    wait_r[i] <= '0;
                end
            end
            wb_rd_wr_en_r  <= |grant_s;
            wb_rd_addr_r   <= sel_s.rd_addr;
            wb_data_r      <= sel_s.data;
            wb_instr_tag_r <= sel_s.instr_tag;
            wb_instr_r     <= sel_s.instr;
            wb_grant_r     <= grant_s;
            ovf_r          <= ovf_r | (|drop_s);
        end
    end

    assign bus.wb_rd_wr_en  = wb_rd_wr_en_r;
    assign bus.wb_rd_addr   = wb_rd_addr_r;
    assign bus.wb_data      = wb_data_r;
    assign bus.wb_instr_tag = wb_instr_tag_r;
    assign bus.wb_instr     = wb_instr_r;
    assign bus.wb_grant     = wb_grant_r;
    assign bus.wb_stall     = |near_full_s;
    assign bus.ovf_err      = ovf_r;

endmodule
